// File: rtl/voting_pkg.sv
// Shared definitions for the voting machine: candidate count, tally format and FSM encoding.
package voting_pkg;

  localparam int unsigned NumCand  = 4;
  localparam int unsigned TallyW   = 8;
  localparam logic [TallyW-1:0] TallyMax = 8'hFF;

  typedef logic [TallyW-1:0]  tally_t;
  typedef logic [NumCand-1:0] cand_vec_t;

  typedef enum logic [1:0] {
    StIdle,
    StDebounce,
    StCast,
    StWaitRelease
  } vote_state_e;

  // True when exactly one button is seen pressed.
  function automatic logic is_onehot(input cand_vec_t v);
    return $onehot(v);
  endfunction

endpackage

// File: rtl/vote_recorder_if.sv
// Button / mode inputs and tally / pulse outputs of the voting-mode front end.
interface vote_recorder_if;
  import voting_pkg::*;

  logic   mode;
  logic   candidate1_button;
  logic   candidate2_button;
  logic   candidate3_button;
  logic   candidate4_button;
  tally_t candidate1_vote;
  tally_t candidate2_vote;
  tally_t candidate3_vote;
  tally_t candidate4_vote;
  logic   valid_vote_casted;

  modport master (
    output mode, candidate1_button, candidate2_button, candidate3_button, candidate4_button,
    input  candidate1_vote, candidate2_vote, candidate3_vote, candidate4_vote,
    input  valid_vote_casted
  );

  modport slave (
    input  mode, candidate1_button, candidate2_button, candidate3_button, candidate4_button,
    output candidate1_vote, candidate2_vote, candidate3_vote, candidate4_vote,
    output valid_vote_casted
  );

endinterface

// File: rtl/button_sync.sv
// Multi-flop synchroniser for the raw asynchronous candidate buttons.
module button_sync
  import voting_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned Width       = NumCand
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [SYNC_STAGES-1:0][Width-1:0] stage_q;

  // Shift raw buttons through the flop chain; stage 0 is the metastability catcher.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/vote_recorder.sv
// Voting-mode front end: debounces the candidate buttons, accepts one vote per press and
// keeps a saturating tally per candidate.
module vote_recorder
  import voting_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic           clk,
  input  logic           reset,
  vote_recorder_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntDone = CntW'(DEBOUNCE_CYCLES);

  cand_vec_t                 raw;
  cand_vec_t                 s;
  vote_state_e               state_q, state_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  cand_vec_t                 cand_q, cand_d;
  tally_t [NumCand-1:0]      tally_q, tally_d;
  logic                      valid_q, valid_d;

  assign raw = {bus.candidate4_button, bus.candidate3_button,
                bus.candidate2_button, bus.candidate1_button};

  button_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .Width      (NumCand)
  ) u_button_sync (
    .clk  (clk),
    .reset(reset),
    .d_i  (raw),
    .q_o  (s)
  );

  // State register plus counter, latched candidate and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      cand_q  <= '0;
      tally_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      tally_q <= tally_d;
      valid_q <= valid_d;
    end
  end

  // Next-state logic: debounce a single press, then demand a stable full release.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (s != '0) begin
          if (!is_onehot(s)) begin
            state_d = StWaitRelease;
          end else if (!bus.mode) begin
            cand_d  = s;
            cnt_d   = CntW'(1);
            state_d = StDebounce;
          end
        end
      end
      StDebounce: begin
        if (s == cand_q && !bus.mode) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CntDone) state_d = StCast;
        end else begin
          cnt_d   = '0;
          state_d = (s != '0) ? StWaitRelease : StIdle;
        end
      end
      StCast: begin
        cnt_d   = '0;
        state_d = StWaitRelease;
      end
      StWaitRelease: begin
        if (s == '0) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CntDone) begin
            cnt_d   = '0;
            state_d = StIdle;
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Output logic: leaving CAST bumps the latched candidate's tally (saturating) and pulses.
  always_comb begin
    tally_d = tally_q;
    valid_d = 1'b0;
    if (state_q == StCast) begin
      valid_d = 1'b1;
      for (int unsigned i = 0; i < NumCand; i++) begin
        if (cand_q[i] && tally_q[i] != TallyMax) tally_d[i] = tally_q[i] + 1'b1;
      end
    end
  end

  assign bus.candidate1_vote   = tally_q[0];
  assign bus.candidate2_vote   = tally_q[1];
  assign bus.candidate3_vote   = tally_q[2];
  assign bus.candidate4_vote   = tally_q[3];
  assign bus.valid_vote_casted = valid_q;

endmodule

// File: tb/tb_vote_recorder.sv
// Scoreboard bench for vote_recorder: press-level stimulus predicts votes; a monitor checks
// each pulse's timing and the tallies it presents.
module tb_vote_recorder;
  import voting_pkg::*;

  localparam int Deb = 4;
  localparam int Syn = 2;
  localparam int Lat = Syn + Deb + 1;

  typedef struct {
    int                cyc;
    logic [3:0][7:0]   tally;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  exp_t exp_q[$];
  int   model_t[4];
  int   checks = 0;
  int   passed = 0;
  int   pulses = 0;
  int   votes_expected = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vote_recorder_if bus ();

  vote_recorder #(
    .DEBOUNCE_CYCLES(Deb),
    .SYNC_STAGES    (Syn)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic int tally_of(input int c);
    case (c)
      0:       return int'(bus.candidate1_vote);
      1:       return int'(bus.candidate2_vote);
      2:       return int'(bus.candidate3_vote);
      default: return int'(bus.candidate4_vote);
    endcase
  endfunction

  // Monitor: every pulse must match the oldest predicted vote in cycle and tallies.
  always @(negedge clk) begin
    if (bus.valid_vote_casted === 1'b1) begin
      pulses++;
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        for (int i = 0; i < 4; i++) check($sformatf("pulse_tally%0d", i + 1), tally_of(i),
                                          int'(e.tally[i]));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] m);
    bus.candidate1_button = m[0];
    bus.candidate2_button = m[1];
    bus.candidate3_button = m[2];
    bus.candidate4_button = m[3];
  endtask

  task automatic expect_vote(input int c, input int at);
    exp_t e;
    if (model_t[c] < 255) model_t[c]++;
    e.cyc = at;
    for (int i = 0; i < 4; i++) e.tally[i] = 8'(model_t[i]);
    exp_q.push_back(e);
    votes_expected++;
  endtask

  // One press: a vote is due iff exactly one button, voting mode, and held >= Deb cycles.
  task automatic press(input logic [3:0] m, input int hold, input logic md, input int gap);
    int c;
    c = 0;
    for (int i = 0; i < 4; i++) if (m[i]) c = i;
    bus.mode = md;
    drive(m);
    if ($countones(m) == 1 && !md && hold >= Deb) expect_vote(c, cyc + Lat);
    tick(hold);
    drive(4'b0000);
    tick(gap);
    bus.mode = 1'b0;
  endtask

  task automatic check_tallies(input string name);
    for (int i = 0; i < 4; i++) check($sformatf("%s_tally%0d", name, i + 1), tally_of(i),
                                      model_t[i]);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) model_t[i] = 0;
  endtask

  initial begin
    int p0;
    logic [3:0] m;
    for (int i = 0; i < 4; i++) model_t[i] = 0;
    reset    = 1'b1;
    bus.mode = 1'b0;
    drive(4'b0000);
    tick(3);
    reset = 1'b0;
    check_tallies("reset");
    check("reset_valid", int'(bus.valid_vote_casted), 0);
    tick(2);

    // Clean long press of button2.
    press(4'b0010, 20, 1'b0, Deb + 2);
    check_tallies("press2");

    // Bouncy button1: vote counts from the last rising edge.
    drive(4'b0001); tick(2);
    drive(4'b0000); tick(1);
    drive(4'b0001);
    expect_vote(0, cyc + Lat);
    tick(10);
    drive(4'b0000); tick(Deb + 2);
    check_tallies("bounce1");

    // Simultaneous and staggered double presses are rejected.
    press(4'b1100, 10, 1'b0, Deb + 2);
    check_tallies("double");
    drive(4'b0100); tick(2);
    drive(4'b1100); tick(6);
    drive(4'b0000); tick(Deb + 2);
    check_tallies("stagger");
    press(4'b1000, 8, 1'b0, Deb + 2);

    // Result mode ignores presses; voting mode then accepts.
    press(4'b0001, 8, 1'b1, Deb + 2);
    check_tallies("mode1");
    press(4'b0001, 8, 1'b0, Deb + 2);

    // Randomised presses: masks, hold lengths around the debounce boundary, mode.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) < 7) m = 4'b0001 << $urandom_range(0, 3);
      else m = 4'($urandom);
      press(m, int'($urandom_range(1, Deb + 6)), ($urandom_range(0, 4) == 0),
            Deb + 2 + int'($urandom_range(0, 3)));
    end
    check_tallies("random");

    // Saturation on candidate 3.
    p0 = pulses;
    repeat (256) press(4'b0100, Deb + 1, 1'b0, Deb + 2);
    check("sat_tally3", int'(bus.candidate3_vote), 255);
    check("sat_pulses", pulses - p0, 256);

    // Reset while debouncing.
    drive(4'b0001); tick(3);
    drive(4'b0000);
    apply_reset();
    check_tallies("rst_deb");
    check("rst_deb_valid", int'(bus.valid_vote_casted), 0);
    tick(Deb + 2);
    check_tallies("rst_deb_after");

    // A clean press after reset proves the FSM came back idle.
    press(4'b0010, 8, 1'b0, Deb + 2);

    // Reset while in CAST: the vote is lost.
    drive(4'b0001); tick(Syn + Deb);
    drive(4'b0000);
    apply_reset();
    check_tallies("rst_cast");
    check("rst_cast_valid", int'(bus.valid_vote_casted), 0);
    tick(Lat + 2);
    check_tallies("rst_cast_after");

    tick(Lat + 4);
    check("queue_drained", exp_q.size(), 0);
    check("pulse_count", pulses, votes_expected);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
